mem_dbus_ctrl: RTL and testbench

MEM_DBUS_CTRL -- requirements
Module: mem_dbus_ctrl

---
 rtl/mem_dbus_ctrl_pkg.sv | 44 ++++
 rtl/mem_dbus_ctrl_align.sv | 48 ++++
 rtl/mem_dbus_ctrl.sv | 115 +++++++++++
 tb/tb_mem_dbus_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dbus_ctrl_pkg.sv
// Shared data-bus types and byte-strobe constants for the MEM-stage bus controller.
// The request/response structs are the contract with the external bus responder.
package mem_dbus_ctrl_pkg;

  localparam int DBUS_XLEN = 64;

  typedef enum logic [1:0] {
    MSIZE_B = 2'd0,
    MSIZE_H = 2'd1,
    MSIZE_W = 2'd2,
    MSIZE_D = 2'd3
  } msize_t;

  localparam logic [7:0] STRB_B = 8'h01;
  localparam logic [7:0] STRB_H = 8'h03;
  localparam logic [7:0] STRB_W = 8'h0F;
  localparam logic [7:0] STRB_D = 8'hFF;

  typedef struct packed {
    logic                 valid;
    logic [DBUS_XLEN-1:0] addr;
    msize_t               size;
    logic [7:0]           strobe;
    logic [DBUS_XLEN-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic                 addr_ok;
    logic                 data_ok;
    logic [DBUS_XLEN-1:0] data;
  } dbus_resp_t;

  function automatic logic [7:0] size_mask(input msize_t s);
    logic [7:0] m;
    case (s)
      MSIZE_B: m = STRB_B;
      MSIZE_H: m = STRB_H;
      MSIZE_W: m = STRB_W;
      default: m = STRB_D;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_dbus_ctrl_align.sv
// Byte-lane alignment: misalignment detect, store strobe/lane placement and
// load result extraction with sign/zero extension. Purely combinational.
module mem_align
  import mem_dbus_ctrl_pkg::*;
(
  input  msize_t      msize,
  input  logic [2:0]  offset,
  input  logic        is_store,
  input  logic        is_unsigned,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata_raw,
  output logic        misaligned,
  output logic [7:0]  strobe,
  output logic [63:0] lane_data,
  output logic [63:0] rdata_ext
);

  logic [63:0] rshift;

  always_comb begin
    case (msize)
      MSIZE_B: misaligned = 1'b0;
      MSIZE_H: misaligned = offset[0];
      MSIZE_W: misaligned = |offset[1:0];
      default: misaligned = |offset;
    endcase
  end

  // Loads carry no strobe and no data toward the bus.
  always_comb begin
    strobe    = is_store ? (size_mask(msize) << offset) : 8'h00;
    lane_data = is_store ? (wdata << {offset, 3'b000}) : 64'h0;
  end

  always_comb begin
    rshift = rdata_raw >> {offset, 3'b000};
    case (msize)
      MSIZE_B: rdata_ext = is_unsigned ? {56'h0, rshift[7:0]}
                                       : {{56{rshift[7]}}, rshift[7:0]};
      MSIZE_H: rdata_ext = is_unsigned ? {48'h0, rshift[15:0]}
                                       : {{48{rshift[15]}}, rshift[15:0]};
      MSIZE_W: rdata_ext = is_unsigned ? {32'h0, rshift[31:0]}
                                       : {{32{rshift[31]}}, rshift[31:0]};
      default: rdata_ext = rshift;
    endcase
  end

endmodule

// File: rtl/mem_dbus_ctrl.sv
// MEM-stage data-bus controller: issues one bus request per load/store, stalls the
// front of the pipeline until data_ok, and presents the extended load result in DONE.
module mem_dbus_ctrl
  import mem_dbus_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_valid,
  input  logic            is_load,
  input  logic            is_store,
  input  msize_t          msize,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output dbus_req_t       dreq,
  input  dbus_resp_t      dresp,
  output logic            handshake_stall,
  output logic [XLEN-1:0] mem_rdata,
  output logic            misalign
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] rdata_q;

  logic            access;
  logic            misaligned;
  logic            start;
  logic            in_busy;
  logic [7:0]      strobe;
  logic [63:0]     lane_data;
  logic [63:0]     rdata_ext;
  logic [63:0]     load_capture;
  logic            unused_addr_ok;

  // addr_ok is informational only; completion is signalled by data_ok alone.
  assign unused_addr_ok = dresp.addr_ok;

  mem_align u_align (
    .msize       (msize),
    .offset      (addr[2:0]),
    .is_store    (is_store),
    .is_unsigned (is_unsigned),
    .wdata       (wdata),
    .rdata_raw   (dresp.data),
    .misaligned  (misaligned),
    .strobe      (strobe),
    .lane_data   (lane_data),
    .rdata_ext   (rdata_ext)
  );

  always_comb begin
    access  = is_load | is_store;
    in_busy = (state == BUSY);
    start   = (state == IDLE) & mem_valid & access & ~misaligned;
  end

  // Request fields track the MEM inputs directly; the stall keeps them frozen
  // for the whole transaction, so no separate request register is needed.
  always_comb begin
    dreq        = '0;
    dreq.valid  = start | in_busy;
    dreq.addr   = addr;
    dreq.size   = msize;
    dreq.strobe = strobe;
    dreq.data   = lane_data;
  end

  always_comb begin
    handshake_stall = start | in_busy;
    misalign        = (state == IDLE) & mem_valid & access & misaligned;
    mem_rdata       = (state == DONE) ? rdata_q : '0;
    load_capture    = is_load ? rdata_ext : 64'h0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (dresp.data_ok) begin
              state   <= DONE;
              rdata_q <= load_capture;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (dresp.data_ok) begin
            state   <= DONE;
            rdata_q <= load_capture;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Self-checking bench for mem_dbus_ctrl: vector table of accesses driven through a
// modelled bus responder, load results checked via a scoreboard queue.
module tb_mem_dbus_ctrl;
  import mem_dbus_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic        mem_valid;
  logic        is_load;
  logic        is_store;
  msize_t      msize;
  logic        is_unsigned;
  logic [63:0] addr;
  logic [63:0] wdata;
  dbus_req_t   dreq;
  dbus_resp_t  dresp;
  logic        handshake_stall;
  logic [63:0] mem_rdata;
  logic        misalign;

  mem_dbus_ctrl #(.XLEN(64)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_valid       (mem_valid),
    .is_load         (is_load),
    .is_store        (is_store),
    .msize           (msize),
    .is_unsigned     (is_unsigned),
    .addr            (addr),
    .wdata           (wdata),
    .dreq            (dreq),
    .dresp           (dresp),
    .handshake_stall (handshake_stall),
    .mem_rdata       (mem_rdata),
    .misalign        (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    msize_t      size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rsp;
    int          delay;
    logic        mis;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [63:0] rdata;
  } vec_t;

  int          passed;
  int          total;
  logic [63:0] sb[$];
  vec_t        vecs[16];

  function automatic vec_t mk(input logic ld, input logic st, input msize_t size,
                              input logic uns, input logic [63:0] a, input logic [63:0] wd,
                              input logic [63:0] rsp, input int delay, input logic mis,
                              input logic [7:0] strobe, input logic [63:0] data,
                              input logic [63:0] rdata);
    vec_t v;
    v.ld = ld; v.st = st; v.size = size; v.uns = uns; v.addr = a; v.wdata = wd;
    v.rsp = rsp; v.delay = delay; v.mis = mis; v.strobe = strobe; v.data = data;
    v.rdata = rdata;
    return v;
  endfunction

  function automatic logic [63:0] lane_mask(input logic [7:0] s);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{s[b]}};
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; msize = MSIZE_B;
    is_unsigned = 1'b0; addr = 64'h0; wdata = 64'h0;
    dresp.addr_ok = 1'b0; dresp.data_ok = 1'b0; dresp.data = 64'h0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          valid_cnt;
    int          stall_cnt;
    logic [63:0] exp;
    @(posedge clk); #1;
    mem_valid = 1'b1; is_load = v.ld; is_store = v.st; msize = v.size;
    is_unsigned = v.uns; addr = v.addr; wdata = v.wdata;
    dresp.addr_ok = 1'b1; dresp.data_ok = (v.delay == 0); dresp.data = v.rsp;
    if (v.mis) begin
      @(negedge clk);
      chk($sformatf("v%0d misalign", idx), 64'(misalign), 64'd1);
      chk($sformatf("v%0d mis valid", idx), 64'(dreq.valid), 64'd0);
      chk($sformatf("v%0d mis stall", idx), 64'(handshake_stall), 64'd0);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk($sformatf("v%0d misalign pulse", idx), 64'(misalign), 64'd0);
      chk($sformatf("v%0d mis after valid", idx), 64'(dreq.valid), 64'd0);
      return;
    end
    if (v.ld) sb.push_back(v.rdata);
    valid_cnt = 0;
    stall_cnt = 0;
    for (int c = 0; c <= v.delay; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        dresp.data_ok = (c == v.delay);
      end
      @(negedge clk);
      valid_cnt += int'(dreq.valid);
      stall_cnt += int'(handshake_stall);
      if (c == 0) begin
        chk($sformatf("v%0d misalign low", idx), 64'(misalign), 64'd0);
        chk($sformatf("v%0d rdata idle", idx), mem_rdata, 64'h0);
        chk($sformatf("v%0d addr", idx), dreq.addr, v.addr);
        chk($sformatf("v%0d size", idx), 64'(dreq.size), 64'(v.size));
        chk($sformatf("v%0d strobe", idx), 64'(dreq.strobe), 64'(v.strobe));
        chk($sformatf("v%0d wdata lane", idx), dreq.data & lane_mask(v.strobe), v.data);
      end
    end
    @(posedge clk); #1;
    dresp.data_ok = 1'b0;
    dresp.data = 64'h0;
    @(negedge clk);
    chk($sformatf("v%0d valid cycles", idx), 64'(valid_cnt), 64'(v.delay + 1));
    chk($sformatf("v%0d stall cycles", idx), 64'(stall_cnt), 64'(v.delay + 1));
    chk($sformatf("v%0d done valid", idx), 64'(dreq.valid), 64'd0);
    chk($sformatf("v%0d done stall", idx), 64'(handshake_stall), 64'd0);
    if (v.ld) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL v%0d scoreboard: got empty queue expected entry", idx);
      end else begin
        exp = sb.pop_front();
        chk($sformatf("v%0d mem_rdata", idx), mem_rdata, exp);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    passed = 0;
    total  = 0;
    vecs[0]  = mk(1, 0, MSIZE_D, 0, 64'h80000008, 64'h0, 64'h1122334455667788, 3, 0,
                  8'h00, 64'h0, 64'h1122334455667788);
    vecs[1]  = mk(1, 0, MSIZE_B, 0, 64'h80000003, 64'h0, 64'h0000000080FF0000, 1, 0,
                  8'h00, 64'h0, 64'hFFFFFFFFFFFFFF80);
    vecs[2]  = mk(1, 0, MSIZE_B, 1, 64'h80000003, 64'h0, 64'h0000000080FF0000, 1, 0,
                  8'h00, 64'h0, 64'h0000000000000080);
    vecs[3]  = mk(0, 1, MSIZE_H, 0, 64'h80000006, 64'hABCD, 64'h0, 0, 0,
                  8'hC0, 64'hABCD000000000000, 64'h0);
    vecs[4]  = mk(1, 0, MSIZE_W, 0, 64'h80000002, 64'h0, 64'h0, 0, 1,
                  8'h00, 64'h0, 64'h0);
    vecs[5]  = mk(1, 0, MSIZE_H, 0, 64'h80000006, 64'h0, 64'h8001000000000000, 2, 0,
                  8'h00, 64'h0, 64'hFFFFFFFFFFFF8001);
    vecs[6]  = mk(1, 0, MSIZE_W, 1, 64'h80000004, 64'h0, 64'hDEADBEEF00000000, 0, 0,
                  8'h00, 64'h0, 64'h00000000DEADBEEF);
    vecs[7]  = mk(1, 0, MSIZE_W, 0, 64'h80000004, 64'h0, 64'hDEADBEEF00000000, 0, 0,
                  8'h00, 64'h0, 64'hFFFFFFFFDEADBEEF);
    vecs[8]  = mk(0, 1, MSIZE_B, 0, 64'h80000005, 64'h1234567890ABCD5A, 64'h0, 1, 0,
                  8'h20, 64'h00005A0000000000, 64'h0);
    vecs[9]  = mk(0, 1, MSIZE_W, 0, 64'h80000004, 64'h00000000CAFEF00D, 64'h0, 2, 0,
                  8'hF0, 64'hCAFEF00D00000000, 64'h0);
    vecs[10] = mk(0, 1, MSIZE_D, 0, 64'h80000000, 64'h0123456789ABCDEF, 64'h0, 0, 0,
                  8'hFF, 64'h0123456789ABCDEF, 64'h0);
    vecs[11] = mk(0, 1, MSIZE_D, 0, 64'h80000004, 64'h1, 64'h0, 0, 1,
                  8'h00, 64'h0, 64'h0);
    vecs[12] = mk(1, 0, MSIZE_H, 1, 64'h80000001, 64'h0, 64'h0, 0, 1,
                  8'h00, 64'h0, 64'h0);
    vecs[13] = mk(1, 0, MSIZE_H, 1, 64'h80000002, 64'h0, 64'h00000000F00D0000, 0, 0,
                  8'h00, 64'h0, 64'h000000000000F00D);
    vecs[14] = mk(1, 0, MSIZE_B, 0, 64'h80000007, 64'h0, 64'h7F00000000000000, 0, 0,
                  8'h00, 64'h0, 64'h000000000000007F);
    vecs[15] = mk(1, 0, MSIZE_D, 0, 64'h80000010, 64'h0, 64'hCAFEBABE12345678, 0, 0,
                  8'h00, 64'h0, 64'hCAFEBABE12345678);

    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset valid", 64'(dreq.valid), 64'd0);
    chk("reset stall", 64'(handshake_stall), 64'd0);
    chk("reset rdata", mem_rdata, 64'h0);
    chk("reset misalign", 64'(misalign), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Back-to-back zero-latency loads appear at indices 6/7 and 14/15.
    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

    // Reset during the second BUSY wait cycle abandons the access.
    @(posedge clk); #1;
    mem_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; msize = MSIZE_D;
    is_unsigned = 1'b0; addr = 64'h80000018; dresp.data_ok = 1'b0;
    dresp.data = 64'hFFFF0000FFFF0000;
    @(negedge clk);
    chk("rst issue valid", 64'(dreq.valid), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst busy1 stall", 64'(handshake_stall), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst busy2 valid", 64'(dreq.valid), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("post rst valid", 64'(dreq.valid), 64'd0);
    chk("post rst stall", 64'(handshake_stall), 64'd0);
    chk("post rst rdata", mem_rdata, 64'h0);
    run_vec(100, mk(1, 0, MSIZE_W, 0, 64'h80000020, 64'h0, 64'h0000000087654321, 1, 0,
                    8'h00, 64'h0, 64'hFFFFFFFF87654321));

    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("final idle rdata", mem_rdata, 64'h0);
    chk("scoreboard drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
